// File: rtl/pacer_pkg.sv
// Shared definitions for the step pacer: FSM state encoding and the speed-ramp decision.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package pacer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_MOVE = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    // Trapezoidal ramp. rem is the distance still to travel after the step just
    // taken. Decelerating takes (dmax - cur) more steps to get back to the
    // slowest code, so once rem fits inside that budget we start slowing down.
    // Evaluated at 32 bits so callers of any width share one implementation;
    // cur never exceeds dmax, so dmax - cur cannot underflow.
    function automatic logic [31:0] ramp_next(input logic [31:0] cur,
                                              input logic [31:0] rem,
                                              input logic [31:0] dmin,
                                              input logic [31:0] dmax);
        if (rem <= dmax - cur) begin
            return (cur >= dmax) ? dmax : cur + 32'd1;
        end
        return (cur <= dmin) ? dmin : cur - 32'd1;
    endfunction

endpackage

// File: rtl/pacer_ramp.sv
// Next delay code for the speed ramp, saturated to [DELAY_MIN, DELAY_MAX].
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is loaded.
// Ports: dly_delay (current code), rem (distance left after this step),
//        next_delay (code to load on the expiry cycle).
module pacer_ramp
    import pacer_pkg::*;
#(
    parameter int POS_BITS   = 10,
    parameter int DELAY_BITS = 4,
    parameter int DELAY_MIN  = 2,
    parameter int DELAY_MAX  = 15
) (
    input  logic [DELAY_BITS-1:0] dly_delay,
    input  logic [POS_BITS:0]     rem,
    output logic [DELAY_BITS-1:0] next_delay
);

    assign next_delay = DELAY_BITS'(ramp_next(32'(dly_delay), 32'(rem),
                                              32'(DELAY_MIN), 32'(DELAY_MAX)));

endmodule

// File: rtl/step_pacer.sv
// Walks one coordinate toward a target, one pixel per delay_unit expiry, with a
// trapezoidal speed ramp. Latency: first step 2*DELAY_MAX+3 cycles after LOAD.
// Backpressure: start is ignored unless IDLE; abort stops the move at once.
// Ports: clk/reset; start/abort/target from game logic; pos/busy/step/done to the
//        sprite logic; dly_reset/dly_enable/dly_delay/dly_waiting to the delay_unit.
module step_pacer
    import pacer_pkg::*;
#(
    parameter int POS_BITS   = 10,
    parameter int DELAY_BITS = 4,
    parameter int DELAY_MAX  = 15,
    parameter int DELAY_MIN  = 2,
    parameter int INIT_POS   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [POS_BITS-1:0]   target,
    output logic [POS_BITS-1:0]   pos,
    output logic                  busy,
    output logic                  step,
    output logic                  done,
    output logic                  dly_reset,
    output logic                  dly_enable,
    output logic [DELAY_BITS-1:0] dly_delay,
    input  logic                  dly_waiting
);

    localparam logic [DELAY_BITS-1:0] D_MAX = DELAY_BITS'(DELAY_MAX);
    localparam logic [POS_BITS-1:0]   P_INIT = POS_BITS'(INIT_POS);

    state_t                state, state_nx;
    logic [POS_BITS-1:0]   tgt, tgt_nx;
    logic                  dir, dir_nx;        // 1 = counting up
    logic [POS_BITS-1:0]   pos_nx, pos_step;
    logic [POS_BITS:0]     rem;
    logic [DELAY_BITS-1:0] delay_nx, ramp_delay;
    logic                  step_nx, done_nx;

    // Candidate position and remaining distance if this cycle is an expiry.
    // The move always stops at the target, so pos_step never wraps.
    assign pos_step = dir ? pos + POS_BITS'(1) : pos - POS_BITS'(1);
    assign rem      = dir ? ({1'b0, tgt} - {1'b0, pos_step})
                          : ({1'b0, pos_step} - {1'b0, tgt});

    pacer_ramp #(
        .POS_BITS   (POS_BITS),
        .DELAY_BITS (DELAY_BITS),
        .DELAY_MIN  (DELAY_MIN),
        .DELAY_MAX  (DELAY_MAX)
    ) u_ramp (
        .dly_delay  (dly_delay),
        .rem        (rem),
        .next_delay (ramp_delay)
    );

    always_comb begin
        state_nx = state;
        tgt_nx   = tgt;
        dir_nx   = dir;
        pos_nx   = pos;
        delay_nx = dly_delay;
        step_nx  = 1'b0;
        done_nx  = 1'b0;
        case (state)
            ST_IDLE: begin
                // abort is not looked at here, so start wins a tie
                if (start) begin
                    if (target != pos) begin
                        tgt_nx   = target;
                        dir_nx   = (target > pos);
                        delay_nx = D_MAX;
                        state_nx = ST_LOAD;
                    end else begin
                        state_nx = ST_FIN;
                    end
                end
            end
            ST_LOAD: begin
                // One cycle with dly_reset high flushes any stale count
                state_nx = abort ? ST_IDLE : ST_MOVE;
            end
            ST_MOVE: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                end else if (!dly_waiting) begin
                    pos_nx  = pos_step;
                    step_nx = 1'b1;
                    if (rem == '0) begin
                        state_nx = ST_FIN;
                    end else begin
                        // Loaded on the expiry cycle, while the delay_unit
                        // counter restarts, so each interval uses one code.
                        delay_nx = ramp_delay;
                    end
                end
            end
            ST_FIN: begin
                done_nx  = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            tgt        <= P_INIT;
            dir        <= 1'b0;
            pos        <= P_INIT;
            busy       <= 1'b0;
            step       <= 1'b0;
            done       <= 1'b0;
            dly_reset  <= 1'b1;
            dly_enable <= 1'b0;
            dly_delay  <= D_MAX;
        end else begin
            state      <= state_nx;
            tgt        <= tgt_nx;
            dir        <= dir_nx;
            pos        <= pos_nx;
            step       <= step_nx;
            done       <= done_nx;
            dly_delay  <= delay_nx;
            // Handshake outputs follow the state being entered so they line
            // up with it rather than trailing by a cycle.
            busy       <= (state_nx == ST_LOAD) || (state_nx == ST_MOVE);
            dly_enable <= (state_nx == ST_MOVE);
            dly_reset  <= (state_nx != ST_MOVE);
        end
    end

endmodule

// File: tb/tb_step_pacer.sv
module tb_step_pacer;

    localparam int PB   = 10;
    localparam int DB   = 4;
    localparam int DMAX = 4;
    localparam int DMIN = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [PB-1:0] target;
    logic [PB-1:0] pos;
    logic          busy, step, done;
    logic          dly_reset, dly_enable;
    logic [DB-1:0] dly_delay;
    logic          dly_waiting;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int model_pos = 0;

    int step_cyc_q[$];
    int step_pos_q[$];
    int done_q[$];
    int en_seen;
    int dmin_seen;

    step_pacer #(
        .POS_BITS   (PB),
        .DELAY_BITS (DB),
        .DELAY_MAX  (DMAX),
        .DELAY_MIN  (DMIN),
        .INIT_POS   (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .target      (target),
        .pos         (pos),
        .busy        (busy),
        .step        (step),
        .done        (done),
        .dly_reset   (dly_reset),
        .dly_enable  (dly_enable),
        .dly_delay   (dly_delay),
        .dly_waiting (dly_waiting)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Paired delay_unit, COUNTER_DIVISION=0: expiry every 2d+2 cycles while enabled.
    logic [5:0] du_cnt;
    always @(posedge clk) begin
        if (dly_reset) begin
            du_cnt      <= '0;
            dly_waiting <= 1'b1;
        end else if (dly_enable) begin
            if (du_cnt >= {1'b0, dly_delay, 1'b1}) begin
                du_cnt      <= '0;
                dly_waiting <= 1'b0;
            end else begin
                du_cnt      <= du_cnt + 6'd1;
                dly_waiting <= 1'b1;
            end
        end else begin
            dly_waiting <= 1'b1;
        end
    end

    // Event monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (step) begin
            step_cyc_q.push_back(cyc);
            step_pos_q.push_back(int'(pos));
        end
        if (done) done_q.push_back(cyc);
        if (dly_enable) en_seen = 1;
        if (busy && int'(dly_delay) < dmin_seen) dmin_seen = int'(dly_delay);
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        step_cyc_q.delete();
        step_pos_q.delete();
        done_q.delete();
        en_seen   = 0;
        dmin_seen = 99;
    endtask

    // One complete move from model_pos to tgt; called on a falling edge.
    task automatic do_move(input int tgt, input bit with_abort, input bit poke);
        int p, n, d, c, s, exp_done, budget;
        int ec[$];
        int ep[$];
        p = model_pos;
        n = (tgt > p) ? tgt - p : p - tgt;
        s = cyc;
        // Reference: start seen at edge s+1 (LOAD), MOVE from s+2, first expiry
        // after 2*DMAX+2 cycles, step visible one cycle later; each later step
        // 2d+2 after the previous one with d taken from the ramp rule.
        if (n == 0) begin
            exp_done = s + 2;
        end else begin
            d = DMAX;
            c = s + 2 * DMAX + 5;
            for (int k = 1; k <= n; k++) begin
                int r;
                ec.push_back(c);
                ep.push_back((tgt > p) ? p + k : p - k);
                r = n - k;
                if (r == 0) break;
                if (r <= DMAX - d) d = (d + 1 > DMAX) ? DMAX : d + 1;
                else               d = (d - 1 < DMIN) ? DMIN : d - 1;
                c += 2 * d + 2;
            end
            exp_done = c + 1;
        end

        clear_mon();
        target = PB'(tgt);
        start  = 1'b1;
        abort  = with_abort;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        if (poke && n != 0) begin
            repeat (4) @(negedge clk);
            target = PB'((tgt + 7) % 1024);
            start  = 1'b1;
            @(negedge clk);
            start  = 1'b0;
        end
        budget = 0;
        while (done_q.size() == 0 && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        repeat (3) @(negedge clk);

        chk("n_steps", step_cyc_q.size(), ec.size());
        for (int i = 0; i < ec.size() && i < step_cyc_q.size(); i++) begin
            chk("step_cyc", step_cyc_q[i] - s, ec[i] - s);
            chk("step_pos", step_pos_q[i], ep[i]);
        end
        chk("done_cnt", done_q.size(), 1);
        chk("done_cyc", (done_q.size() > 0) ? done_q[0] - s : -1, exp_done - s);
        chk("final_pos", int'(pos), tgt);
        chk("busy_after", int'(busy), 0);
        if (n == 0) chk("en_zero_move", en_seen, 0);
        model_pos = tgt;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        reset  = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        target = '0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_pos",    int'(pos), 0);
        chk("rst_busy",   int'(busy), 0);
        chk("rst_step",   int'(step), 0);
        chk("rst_done",   int'(done), 0);
        chk("rst_dreset", int'(dly_reset), 1);
        chk("rst_denable",int'(dly_enable), 0);
        chk("rst_delay",  int'(dly_delay), DMAX);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_dreset", int'(dly_reset), 1);

        // Ramp up then down, same-position move, downward move with ignored start
        do_move(5, 1'b0, 1'b0);
        do_move(5, 1'b0, 1'b0);
        do_move(2, 1'b0, 1'b1);

        // Long move: cruise at DMIN
        do_move(100, 1'b0, 1'b0);
        chk("cruise_min", dmin_seen, DMIN);

        // Abort landing on an expiry cycle: no step taken
        clear_mon();
        target = PB'(model_pos + 5);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        budget = 0;
        while (dly_waiting && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        chk("expiry_seen", int'(dly_waiting), 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_exp_steps", step_cyc_q.size(), 0);
        chk("abort_exp_pos",   int'(pos), model_pos);
        chk("abort_exp_busy",  int'(busy), 0);
        chk("abort_exp_done",  done_q.size(), 0);

        // Abort while idle does nothing
        clear_mon();
        abort = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_busy", int'(busy), 0);
        chk("idle_abort_pos",  int'(pos), model_pos);
        chk("idle_abort_done", done_q.size(), 0);

        // start and abort together in IDLE: start wins
        do_move(90, 1'b1, 1'b0);

        // Reset in the middle of a move
        target = PB'(600);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        repeat (30) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_pos",     int'(pos), 0);
        chk("mid_rst_dreset",  int'(dly_reset), 1);
        chk("mid_rst_denable", int'(dly_enable), 0);
        chk("mid_rst_busy",    int'(busy), 0);
        chk("mid_rst_delay",   int'(dly_delay), DMAX);
        reset = 1'b0;
        model_pos = 0;
        repeat (2) @(negedge clk);

        // Abort after two steps, then a clean move back to 0
        clear_mon();
        target = PB'(20);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        budget = 0;
        while (step_cyc_q.size() < 2 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        chk("abort2_steps_seen", step_cyc_q.size(), 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort2_busy",    int'(busy), 0);
        chk("abort2_denable", int'(dly_enable), 0);
        chk("abort2_pos",     int'(pos), 2);
        clear_mon();
        repeat (40) @(negedge clk);
        chk("abort2_no_step", step_cyc_q.size(), 0);
        chk("abort2_no_done", done_q.size(), 0);
        chk("abort2_hold",    int'(pos), 2);
        model_pos = 2;
        do_move(0, 1'b0, 1'b0);

        // Random moves
        for (int i = 0; i < 8; i++) begin
            do_move(int'($urandom_range(0, 200)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
